fft_frame_sequencer: RTL
========================

Name: fft_frame_sequencer

Overview:
- Parametrised successor to the single-stage FFT register wrapper: owns the N-sample frame buffer and sequences all log2(N) stages of the butterfly engine.
- Accepts samples as a valid/ready stream, optionally stored in bit-reversed order.
- Per stage: requests the coefficient fill, starts the engine and writes its result back into the buffer.
- Streams the finished frame out over valid/ready.

Parameters:
- N, 16, FFT points; power of two, 4..256.
- MSB, 16, sample word width in bits.
- BITREV, 1, 1 = load sample k at buffer index bitrev(k); 0 = natural order.
- SW, $clog2($clog2(N)) (min 1), width of the stage index.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept a sample.
- in_data  in  MSB  input sample.
- fill_regs  out  1  one-cycle pulse: coefficient mapper starts filling for `stage`.
- coef_done  in  1  coefficient bank filled (pulse or level; sampled only in COEF).
- start_calc  out  1  one-cycle pulse: engine starts the current stage.
- calc_finish  in  1  engine result valid on stage_result (sampled only in CALC).
- stage  out  SW  current stage index, 0..log2(N)-1.
- stage_data  out  N*MSB  frame buffer contents fed to the engine; word i at bits [i*MSB +: MSB].
- stage_result  in  N*MSB  engine output, same packing.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts a sample.
- out_data  out  MSB  output sample, natural buffer index order 0..N-1.
- out_last  out  1  high with the sample at index N-1.
- busy  out  1  high in any state other than LOAD.

Behaviour:
Reset (async, rst_n=0):
- State = LOAD; load counter, stage and unload counter = 0.
- Buffer is cleared to 0.
- in_ready=1; all other outputs 0.

LOAD:
- in_ready=1.
- On in_valid&&in_ready: write in_data to buffer[BITREV ? bitrev(cnt) : cnt], then cnt++.
- The write that takes cnt from N-1 sets stage=0 and moves to COEF.
- Also in that same cycle: in_ready drops to 0 next cycle and fill_regs pulses next cycle, i.e. the first cycle in COEF.

COEF:
- fill_regs is high only on the first cycle of COEF.
- Wait for coef_done=1, then move to CALC; start_calc pulses on the first CALC cycle.
- coef_done arriving in the same cycle as the fill_regs pulse is accepted.

CALC:
- Wait for calc_finish=1.
- On that cycle, latch stage_result into the buffer, all N words at once.
- If stage == log2(N)-1: go to UNLOAD.
- Otherwise: stage++ and go to COEF.
- Latency from the last input handshake to the first start_calc is 2 cycles when coef_done is asserted combinationally with fill_regs.

UNLOAD:
- out_valid=1; out_data = buffer[ucnt]; out_last = (ucnt == N-1).
- On out_valid&&out_ready: ucnt++.
- The handshake at ucnt=N-1 clears all counters and stage, and returns to LOAD with in_ready=1 next cycle.
- out_data is held stable while out_ready=0.
- Samples cannot overlap across frames: in_ready=0 throughout COEF/CALC/UNLOAD.

Signal timing:
- stage_data always reflects the registered buffer; it is stable during COEF and CALC.
- fill_regs and start_calc never assert in the same cycle.

Spurious inputs:
- coef_done and calc_finish outside their respective states are ignored.
- in_valid outside LOAD is ignored and the data is dropped.

Reset mid-operation:
- Any state returns to LOAD immediately with the buffer cleared.
- No pulse outputs are emitted on reset deassertion.

Widths and arithmetic:
- Counters are $clog2(N) bits; stage is SW bits.
- No arithmetic on data words; the engine owns scaling.
- bitrev reverses the $clog2(N) index bits.

Test Plan:
- Bit-reversed load: N=8, BITREV=1, feed 0..7 back-to-back -> buffer words [0,4,2,6,1,5,3,7]; fill_regs pulses 1 cycle after the 8th handshake with stage=0.
- Full sequence: model engine returns stage_data+1 per word 3 cycles after start_calc, coef_done 2 cycles after fill_regs -> exactly 3 fill_regs/start_calc pairs with stage 0,1,2; output = loaded words +3; out_last only on the 8th sample.
- Back-pressure: out_ready toggling 1,0,0,1 -> out_data/out_valid held during stalls; 8 samples in order, none duplicated; in_ready stays 0 until the last transfer, then 1 next cycle.
- Spurious handshakes: calc_finish pulsed in LOAD and COEF, coef_done pulsed in CALC -> no state change, no buffer write.
- Reset mid-CALC of stage 1: rst_n low 1 cycle -> busy=0, in_ready=1, stage=0, buffer all 0, no start_calc after release; a new 8-sample frame completes normally.
- BITREV=0, N=16: feed 0..15 -> stage runs 0..3, output stream 0..15 in order (identity engine).

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// N-point FFT frame sequencer: loads a frame, runs all log2(N) butterfly stages
// through an external engine, then streams the finished frame out.
module fft_frame_sequencer #(
  parameter int N      = 16,
  parameter int MSB    = 16,
  parameter int BITREV = 1,
  parameter int SW     = ($clog2($clog2(N)) < 1) ? 1 : $clog2($clog2(N))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSB-1:0]   in_data,
  output logic             fill_regs,
  input  logic             coef_done,
  output logic             start_calc,
  input  logic             calc_finish,
  output logic [SW-1:0]    stage,
  output logic [N*MSB-1:0] stage_data,
  input  logic [N*MSB-1:0] stage_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MSB-1:0]   out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int              CW         = $clog2(N);
  localparam logic [CW-1:0]   LAST_IDX   = CW'(N - 1);
  localparam logic [SW-1:0]   LAST_STAGE = SW'(CW - 1);

  typedef enum logic [1:0] {S_LOAD, S_COEF, S_CALC, S_UNLOAD} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, ucnt_q, load_idx;
  logic [SW-1:0]      stage_q;
  logic [N*MSB-1:0]   buf_q;
  logic               fill_q, fill_d, start_q, start_d;
  logic               load_we, calc_we, unload_we;

  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    for (int b = 0; b < CW; b++) r[b] = v[CW-1-b];
    return r;
  endfunction

  assign load_idx = (BITREV != 0) ? bitrev(cnt_q) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      fill_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      start_q <= start_d;
    end
  end

  // Pulses are registered on the transition so each lands on the first cycle of its state.
  always_comb begin
    state_d   = state_q;
    fill_d    = 1'b0;
    start_d   = 1'b0;
    load_we   = 1'b0;
    calc_we   = 1'b0;
    unload_we = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          load_we = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = S_COEF;
            fill_d  = 1'b1;
          end
        end
      end
      S_COEF: begin
        if (coef_done) begin
          state_d = S_CALC;
          start_d = 1'b1;
        end
      end
      S_CALC: begin
        if (calc_finish) begin
          calc_we = 1'b1;
          if (stage_q == LAST_STAGE) begin
            state_d = S_UNLOAD;
          end else begin
            state_d = S_COEF;
            fill_d  = 1'b1;
          end
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          unload_we = 1'b1;
          if (ucnt_q == LAST_IDX) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ucnt_q  <= '0;
      stage_q <= '0;
      buf_q   <= '0;
    end else begin
      if (load_we) begin
        buf_q[int'(load_idx)*MSB +: MSB] <= in_data;
        cnt_q                            <= cnt_q + CW'(1);
      end
      if (calc_we) buf_q <= stage_result;
      if (unload_we) ucnt_q <= ucnt_q + CW'(1);
      if (unload_we && ucnt_q == LAST_IDX) cnt_q <= '0;
      if (load_we && cnt_q == LAST_IDX) stage_q <= '0;
      else if (calc_we && stage_q != LAST_STAGE) stage_q <= stage_q + SW'(1);
      else if (unload_we && ucnt_q == LAST_IDX) stage_q <= '0;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q != S_LOAD);
  assign fill_regs  = fill_q;
  assign start_calc = start_q;
  assign stage      = stage_q;
  assign stage_data = buf_q;
  assign out_valid  = (state_q == S_UNLOAD);
  assign out_last   = (state_q == S_UNLOAD) && (ucnt_q == LAST_IDX);
  assign out_data   = (state_q == S_UNLOAD) ? buf_q[int'(ucnt_q)*MSB +: MSB] : '0;

endmodule
